regf_wr_arbiter: RTL and testbench
==================================

# regf_wr_arbiter

Write-port arbiter and scoreboard for the 8-entry × 8-bit register file (r0 reads as zero). It shares the file's single write port between two writeback requesters (ALU, load unit) using valid/ready handshakes, a one-entry holding slot per requester and round-robin grant. It drives the file's write-enable, destination-address and write-data inputs from a registered output stage. It also exports a per-register pending mask so the decode stage can stall reads of registers with writes in flight.

## Interface
- `DATA_W`, default 8, register data width.
- `ADDR_W`, default 3, register address width (2**ADDR_W registers).
- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Asynchronous reset, active-high.
- `req0_valid`  in  1  Requester 0 (ALU) has a write.
- `req0_ready`  out  1  Requester 0 slot can accept this cycle.
- `req0_addr`  in  ADDR_W  Requester 0 destination register.
- `req0_data`  in  DATA_W  Requester 0 write data.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as requester 0, for requester 1 (load unit).
- `rf_write`  out  1  Register-file write enable (registered).
- `rf_addr_d`  out  ADDR_W  Register-file destination address (registered).
- `rf_data_in`  out  DATA_W  Register-file write data (registered).
- `pending`  out  2**ADDR_W  Bit a=1 while any write to register a is buffered or in the output stage; bit 0 is always 0.

## Operation
- Each requester owns one slot: valid bit, addr, data.
- Handshake: a transfer occurs on a rising edge with `reqN_valid` && `reqN_ready`.
  - `reqN_ready` = slot empty OR slot granted this cycle. This is combinational from state and grant only, never from `reqN_valid`.
  - Back-to-back transfers at one per cycle per requester are supported.
- Arbitration, each cycle, among full slots:
  - One full slot: it is granted.
  - Both full: the slot named by priority pointer `rr` is granted.
  - After any grant to slot i, `rr` becomes 1-i. `rr` does not change when nothing is granted.
- Granted slot contents load the output stage at the next edge:
  - `rf_write` = 1 if the granted addr ≠ 0.
  - If granted addr = 0, the entry is consumed and `rf_write` = 0 (silent drop); `rf_addr_d`/`rf_data_in` still load.
  - With no grant, `rf_write` = 0 and `rf_addr_d`/`rf_data_in` hold.
- The output stage is single-cycle; the register file commits at the edge after `rf_write` is high.
- `pending[a]` = (slot0 full && addr0==a) | (slot1 full && addr1==a) | (`rf_write` && `rf_addr_d`==a), for a≠0. It is combinational from registers only.
- Both requesters may target the same register. Grant order defines commit order, and `pending[a]` stays high until the last of them commits.

## Timing
- Reset (async assert, sync release):
  - Slots empty; `rr`=0 (requester 0 favoured).
  - `rf_write`=0, `rf_addr_d`=0, `rf_data_in`=0, `pending`=0.
  - `req0_ready`=`req1_ready`=1.
- Latency: accept at edge N → output stage loaded at edge N+1 (`rf_write` high in cycle N+1) → file updated at edge N+2. Read ports see the new value in cycle N+2.
- Contention: the losing slot waits exactly one cycle per competing grant. Its ready stays 0 until it is granted.
- Sustained throughput: one write per cycle total. The losing requester is throttled to alternate cycles under full contention.
- Reset mid-operation: buffered and output-stage writes are discarded and `rf_write` drops immediately (asynchronously). No partial write reaches the file after reset assertion.

## Structure
- Shared package `regf_pkg`: `REGF_ADDR_W`=3, `REGF_DATA_W`=8, `REGF_NUM_REGS`=8, `REGF_ZERO_REG`=0.
- Also in `regf_pkg`: typedef `regf_wr_t` {addr, data} used by slots and the output stage.
- Sub-module `regf_wr_slot`: one-entry holding buffer with load/drain and a full flag, instantiated twice.
- Arbiter, `rr` pointer, output stage and pending logic live in the top module.

## Test plan
- Reset, then a single write: req0 addr=3 data=0x5A → `rf_write`=1, `rf_addr_d`=3, `rf_data_in`=0x5A one cycle after accept. `pending[3]`=1 for exactly 2 cycles; file reads 0x5A at N+2.
- Simultaneous requests: req0 (2, 0x11) and req1 (5, 0x22) in the same cycle after reset → req0 written first, req1 next cycle. `rr` then favours req0 again, and repeated contention alternates grants 0,1,0,1.
- Write to r0: req1 addr=0 data=0xFF → accepted, `rf_write` stays 0, `pending`=0 throughout, r0 still reads 0.
- Same-address race: req0 (4, 0xAA) and req1 (4, 0xBB) together → final r4 = 0xBB. `pending[4]` stays high continuously until the 0xBB commit.
- Backpressure and streaming: both valid for 10 cycles with distinct addrs → 10 writes in 10 cycles, each requester's ready toggles, and no transfer is lost or duplicated (scoreboard check).
- Reset mid-flight: assert `rst` while both slots and the output stage are full → `rf_write`=0 immediately, `pending`=0, and no listed addresses change after release.

Source files
------------

// File: rtl/regf_pkg.sv
// Shared register-file definitions: geometry, write record and the
// round-robin pointer encoding used by the write-port arbiter.
package regf_pkg;

  localparam int unsigned REGF_ADDR_W   = 3;
  localparam int unsigned REGF_DATA_W   = 8;
  localparam int unsigned REGF_NUM_REGS = 8;
  localparam logic [REGF_ADDR_W-1:0] REGF_ZERO_REG = '0;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [REGF_ADDR_W-1:0] addr;
    logic [REGF_DATA_W-1:0] data;
  } regf_wr_t;

  // Which requester wins when both slots hold a write.
  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } regf_rr_e;

endpackage

// File: rtl/regf_wr_arbiter_if.sv
// Writeback handshake bundle between the two requesters and the
// register-file write-port arbiter, plus the arbiter's file-side outputs.
interface regf_wr_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  logic                 rf_write;
  logic [ADDR_W-1:0]    rf_addr_d;
  logic [DATA_W-1:0]    rf_data_in;
  logic [2**ADDR_W-1:0] pending;

  // Requester / environment side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_write, rf_addr_d, rf_data_in, pending
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_write, rf_addr_d, rf_data_in, pending
  );

endinterface

// File: rtl/regf_wr_slot.sv
// One-entry holding buffer for a single writeback requester.
module regf_wr_slot
  import regf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     drain,
  input  regf_wr_t wr_in,
  output logic     full,
  output regf_wr_t wr_out
);

  logic     full_q;
  regf_wr_t entry_q;

  // Load and drain in the same cycle: the new entry replaces the drained one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else if (load) begin
      full_q  <= 1'b1;
      entry_q <= wr_in;
    end else if (drain) begin
      full_q  <= 1'b0;
    end
  end

  assign full   = full_q;
  assign wr_out = entry_q;

endmodule

// File: rtl/regf_wr_arbiter.sv
// Register-file write-port arbiter: two holding slots, round-robin grant,
// registered write stage and per-register pending mask.
module regf_wr_arbiter
  import regf_pkg::*;
#(
  parameter int unsigned DATA_W = REGF_DATA_W,
  parameter int unsigned ADDR_W = REGF_ADDR_W
) (
  input logic clk,
  input logic rst,
  regf_wr_arbiter_if.slave bus
);

  localparam int unsigned NREGS = 2**ADDR_W;

  regf_wr_t   in0, in1, slot0, slot1, out_q;
  logic       full0, full1;
  logic       grant0, grant1;
  logic       load0, load1;
  logic       rf_write_q;
  regf_rr_e   rr;
  logic [NREGS-1:0] pend;

  assign in0   = '{addr: bus.req0_addr, data: bus.req0_data};
  assign in1   = '{addr: bus.req1_addr, data: bus.req1_data};

  // Ready depends only on slot state and grant, never on valid.
  assign bus.req0_ready = !full0 || grant0;
  assign bus.req1_ready = !full1 || grant1;
  assign load0 = bus.req0_valid && bus.req0_ready;
  assign load1 = bus.req1_valid && bus.req1_ready;

  regf_wr_slot u_slot0 (
    .clk    (clk),
    .rst    (rst),
    .load   (load0),
    .drain  (grant0),
    .wr_in  (in0),
    .full   (full0),
    .wr_out (slot0)
  );

  regf_wr_slot u_slot1 (
    .clk    (clk),
    .rst    (rst),
    .load   (load1),
    .drain  (grant1),
    .wr_in  (in1),
    .full   (full1),
    .wr_out (slot1)
  );

  // Grant a lone full slot; break ties with the round-robin pointer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (full0 && full1) begin
      if (rr == RR_REQ0) grant0 = 1'b1;
      else               grant1 = 1'b1;
    end else begin
      grant0 = full0;
      grant1 = full1;
    end
  end

  // Hand priority to the other requester after every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr <= RR_REQ0;
    else if (grant0) rr <= RR_REQ1;
    else if (grant1) rr <= RR_REQ0;
  end

  // Output stage: load the granted entry; writes to r0 are consumed silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_q <= 1'b0;
      out_q      <= '0;
    end else if (grant0) begin
      rf_write_q <= (slot0.addr != REGF_ZERO_REG);
      out_q      <= slot0;
    end else if (grant1) begin
      rf_write_q <= (slot1.addr != REGF_ZERO_REG);
      out_q      <= slot1;
    end else begin
      rf_write_q <= 1'b0;
    end
  end

  // Pending mask from registered state only; r0 is never pending.
  always_comb begin
    pend = '0;
    for (int unsigned a = 1; a < NREGS; a++) begin
      pend[a] = (full0 && (slot0.addr == REGF_ADDR_W'(a))) ||
                (full1 && (slot1.addr == REGF_ADDR_W'(a))) ||
                (rf_write_q && (out_q.addr == REGF_ADDR_W'(a)));
    end
  end

  assign bus.rf_write   = rf_write_q;
  assign bus.rf_addr_d  = out_q.addr;
  assign bus.rf_data_in = out_q.data;
  assign bus.pending    = pend;

endmodule

// File: tb/tb_regf_wr_arbiter.sv
// Self-checking bench for regf_wr_arbiter: cycle table, scoreboard of
// accepted writes, streaming and reset-in-flight sequences.
module tb_regf_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regf_wr_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  regf_wr_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Register-file model: commits on the edge after rf_write is sampled high.
  logic [7:0] rf_model [8];
  logic       init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 8; i++) rf_model[i] <= 8'h00;
    end else if (bus.rf_write) begin
      rf_model[bus.rf_addr_d] <= bus.rf_data_in;
    end
  end

  // Scoreboard: accepted writes per requester, matched in order against the output stage.
  logic [10:0] q0 [$];
  logic [10:0] q1 [$];
  always @(negedge clk) begin
    logic [10:0] got;
    logic [11:0] exp;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (bus.rf_write) begin
        writes++;
        got = {bus.rf_addr_d, bus.rf_data_in};
        if (q0.size() > 0 && q0[0] == got)      exp = {1'b0, q0.pop_front()};
        else if (q1.size() > 0 && q1[0] == got) exp = {1'b0, q1.pop_front()};
        else if (q0.size() > 0)                 exp = {1'b0, q0[0]};
        else if (q1.size() > 0)                 exp = {1'b0, q1[0]};
        else                                    exp = 12'hfff;
        check("sb_write", 32'({1'b0, got}), 32'(exp));
      end
      if (bus.req0_valid && bus.req0_ready && bus.req0_addr != 3'd0)
        q0.push_back({bus.req0_addr, bus.req0_data});
      if (bus.req1_valid && bus.req1_ready && bus.req1_addr != 3'd0)
        q1.push_back({bus.req1_addr, bus.req1_data});
    end
  end

  typedef struct {
    logic       rst;
    logic       v0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       e_rdy0;
    logic       e_rdy1;
    logic       e_wr;
    logic [2:0] e_addr;
    logic [7:0] e_data;
    logic [7:0] e_pend;
  } vec_t;

  function automatic vec_t mk(int r, int v0, int a0, int d0, int v1, int a1, int d1,
                              int er0, int er1, int ew, int ea, int ed, int ep);
    vec_t v;
    v.rst = r[0];   v.v0 = v0[0]; v.a0 = a0[2:0]; v.d0 = d0[7:0];
    v.v1 = v1[0];   v.a1 = a1[2:0]; v.d1 = d1[7:0];
    v.e_rdy0 = er0[0]; v.e_rdy1 = er1[0]; v.e_wr = ew[0];
    v.e_addr = ea[2:0]; v.e_data = ed[7:0]; v.e_pend = ep[7:0];
    return v;
  endfunction

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0, i1, wr_before, stream_wr;
    logic acc0, acc1;
    logic [7:0] snap1, snap3, snap6;

    //             rst v0 a0 d0     v1 a1 d1     r0 r1 wr addr data   pend
    tbl[0]  = mk(0, 1, 3, 8'h5A, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00);
    tbl[1]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h08);
    tbl[2]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 3, 8'h5A, 8'h08);
    tbl[3]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00);
    tbl[4]  = mk(0, 1, 2, 8'h11, 1, 5, 8'h22, 1, 1, 0, 0, 8'h00, 8'h00);
    tbl[5]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h24);
    tbl[6]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 2, 8'h11, 8'h24);
    tbl[7]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 5, 8'h22, 8'h20);
    tbl[8]  = mk(0, 0, 0, 8'h00, 1, 0, 8'hFF, 1, 1, 0, 5, 8'h22, 8'h00);
    tbl[9]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 5, 8'h22, 8'h00);
    tbl[10] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 0, 8'hFF, 8'h00);
    tbl[11] = mk(0, 1, 4, 8'hAA, 1, 4, 8'hBB, 1, 1, 0, 0, 8'hFF, 8'h00);
    tbl[12] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'hFF, 8'h10);
    tbl[13] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 4, 8'hAA, 8'h10);
    tbl[14] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 1, 4, 8'hBB, 8'h10);
    tbl[15] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 4, 8'hBB, 8'h00);

    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    init_done = 1'b1;
    @(negedge clk);
    check("rst_rf_write", 32'(bus.rf_write), 32'(0));
    check("rst_rf_addr_d", 32'(bus.rf_addr_d), 32'(0));
    check("rst_rf_data_in", 32'(bus.rf_data_in), 32'(0));
    check("rst_pending", 32'(bus.pending), 32'(0));
    check("rst_ready0", 32'(bus.req0_ready), 32'(1));
    check("rst_ready1", 32'(bus.req1_ready), 32'(1));
    @(posedge clk); #1;

    // Cycle table: single write, contention, r0 drop, same-address race.
    for (int k = 0; k < NV; k++) begin
      rst = tbl[k].rst;
      bus.req0_valid = tbl[k].v0; bus.req0_addr = tbl[k].a0; bus.req0_data = tbl[k].d0;
      bus.req1_valid = tbl[k].v1; bus.req1_addr = tbl[k].a1; bus.req1_data = tbl[k].d1;
      @(negedge clk);
      check($sformatf("v%0d_ready0", k), 32'(bus.req0_ready), 32'(tbl[k].e_rdy0));
      check($sformatf("v%0d_ready1", k), 32'(bus.req1_ready), 32'(tbl[k].e_rdy1));
      check($sformatf("v%0d_rf_write", k), 32'(bus.rf_write), 32'(tbl[k].e_wr));
      check($sformatf("v%0d_rf_addr_d", k), 32'(bus.rf_addr_d), 32'(tbl[k].e_addr));
      check($sformatf("v%0d_rf_data_in", k), 32'(bus.rf_data_in), 32'(tbl[k].e_data));
      check($sformatf("v%0d_pending", k), 32'(bus.pending), 32'(tbl[k].e_pend));
      @(posedge clk); #1;
    end
    check("file_r3", 32'(rf_model[3]), 32'(8'h5A));
    check("file_r2", 32'(rf_model[2]), 32'(8'h11));
    check("file_r5", 32'(rf_model[5]), 32'(8'h22));
    check("file_r4", 32'(rf_model[4]), 32'(8'hBB));
    check("file_r0", 32'(rf_model[0]), 32'(8'h00));

    // Streaming under full contention: 7 writes per requester.
    i0 = 0; i1 = 0; stream_wr = 0;
    wr_before = writes;
    for (int c = 0; c < 20; c++) begin
      bus.req0_valid = (i0 < 7); bus.req0_addr = 3'(1 + i0 % 3); bus.req0_data = 8'(8'h40 + i0);
      bus.req1_valid = (i1 < 7); bus.req1_addr = 3'(4 + i1 % 3); bus.req1_data = 8'(8'h80 + i1);
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      if (c >= 1 && c <= 9) begin
        check($sformatf("stream_c%0d_ready0", c), 32'(bus.req0_ready), 32'(c % 2));
        check($sformatf("stream_c%0d_ready1", c), 32'(bus.req1_ready), 32'(1 - c % 2));
      end
      if (c >= 2 && c <= 11 && bus.rf_write) stream_wr++;
      @(posedge clk); #1;
      if (acc0) i0++;
      if (acc1) i1++;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("stream_10_in_10", 32'(stream_wr), 32'(10));
    check("stream_accept0", 32'(i0), 32'(7));
    check("stream_accept1", 32'(i1), 32'(7));
    check("stream_total_writes", 32'(writes - wr_before), 32'(14));
    check("stream_q0_empty", 32'(q0.size()), 32'(0));
    check("stream_q1_empty", 32'(q1.size()), 32'(0));

    // Reset with both slots and the output stage occupied.
    bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 8'hD1;
    bus.req1_valid = 1'b1; bus.req1_addr = 3'd6; bus.req1_data = 8'hD6;
    @(negedge clk);
    check("mid_ready0_a", 32'(bus.req0_ready), 32'(1));
    check("mid_ready1_a", 32'(bus.req1_ready), 32'(1));
    @(posedge clk); #1;
    bus.req0_addr = 3'd3; bus.req0_data = 8'hD3;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("mid_ready0_b", 32'(bus.req0_ready), 32'(1));
    check("mid_ready1_b", 32'(bus.req1_ready), 32'(0));
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    snap1 = rf_model[1]; snap3 = rf_model[3]; snap6 = rf_model[6];
    check("mid_pre_rf_write", 32'(bus.rf_write), 32'(1));
    check("mid_pre_pending", 32'(bus.pending), 32'(8'h4A));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rf_write", 32'(bus.rf_write), 32'(0));
    check("mid_rst_pending", 32'(bus.pending), 32'(0));
    check("mid_rst_ready0", 32'(bus.req0_ready), 32'(1));
    check("mid_rst_ready1", 32'(bus.req1_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_after_r1", 32'(rf_model[1]), 32'(snap1));
    check("mid_after_r3", 32'(rf_model[3]), 32'(snap3));
    check("mid_after_r6", 32'(rf_model[6]), 32'(snap6));
    check("mid_after_rf_write", 32'(bus.rf_write), 32'(0));
    check("mid_after_pending", 32'(bus.pending), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
